// File: rtl/seq_detector_if.sv
// seq_detector_if -- serial-stream bundle for seq_detector.
//   en      : din is consumed only when high
//   din     : serial data bit
//   clr     : synchronous soft clear of search state and counter
//   match   : Mealy match flag (combinational)
//   match_q : match registered one cycle later
//   full    : window holds LEN-1 valid bits
//   count   : match counter (only with SEQ_DETECTOR_COUNT_EN defined)
// master = stream source/observer, slave = detector.
interface seq_detector_if #(
  parameter int unsigned CNT_W = 8
);
  logic en;
  logic din;
  logic clr;
  logic match;
  logic match_q;
  logic full;
`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] count;
`endif

  modport master (
    output en, din, clr,
    input  match, match_q, full
`ifdef SEQ_DETECTOR_COUNT_EN
    , input count
`endif
  );

  modport slave (
    input  en, din, clr,
    output match, match_q, full
`ifdef SEQ_DETECTOR_COUNT_EN
    , output count
`endif
  );
endinterface

// File: rtl/seq_detector.sv
// seq_detector -- serial bit-pattern detector with Mealy match output.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset (priority over clr and en)
//   bus  : seq_detector_if.slave (en, din, clr, match, match_q, full, count)
// Parameters: LEN (2..16), PATTERN (PATTERN[LEN-1] received first),
//   OVERLAP (1 = overlapping matches), CNT_W (match counter width).
// Optional feature: define SEQ_DETECTOR_COUNT_EN to build the saturating
//   match counter and its count port; without it no counter exists.
module seq_detector #(
  parameter int unsigned       LEN     = 4,
  parameter logic [LEN-1:0]    PATTERN = LEN'(4'b1011),
  parameter bit                OVERLAP = 1'b1,
  parameter int unsigned       CNT_W   = 8
) (
  input logic           clk,
  input logic           rst,
  seq_detector_if.slave bus
);

  localparam int unsigned FW = $clog2(LEN);

  logic [LEN-2:0] win;
  logic [FW-1:0]  fill;
  logic           match_c;
  logic           full_c;
  logic [LEN-1:0] shifted;
  logic           mq_r;

  always_comb begin
    shifted = {win, bus.din};
    full_c  = (fill == FW'(LEN - 1));
    // rst gates the Mealy term exactly like clr.
    match_c = ~rst & bus.en & ~bus.clr & full_c & (shifted == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      win  <= '0;
      fill <= '0;
      mq_r <= 1'b0;
    end else begin
      mq_r <= match_c;
      if (bus.en) begin
        win <= shifted[LEN-2:0];
        if (match_c && !OVERLAP)
          fill <= '0;
        else if (!full_c)
          fill <= fill + 1'b1;
      end
    end
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk) begin
    if (rst || bus.clr)
      cnt_r <= '0;
    else if (match_c && (cnt_r != '1))
      cnt_r <= cnt_r + 1'b1;
  end

  assign bus.count = cnt_r;
`endif

  assign bus.match   = match_c;
  assign bus.match_q = mq_r;
  assign bus.full    = full_c;

endmodule

// File: tb/tb_seq_detector.sv
module tb_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic din = 1'b0;
  logic clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // a: 1011 overlapping, 2-bit counter; b: 1010 overlapping; c: 1010 restart.
  seq_detector_if #(.CNT_W(2)) ia ();
  seq_detector_if #(.CNT_W(8)) ib ();
  seq_detector_if #(.CNT_W(8)) ic ();

  assign ia.en = en; assign ia.din = din; assign ia.clr = clr;
  assign ib.en = en; assign ib.din = din; assign ib.clr = clr;
  assign ic.en = en; assign ic.din = din; assign ic.clr = clr;

  seq_detector #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  seq_detector #(.LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  seq_detector #(.LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8))
    dut_c (.clk(clk), .rst(rst), .bus(ic));

  typedef struct {
    logic r, c, e, d;
    logic m, mq, f;
    int   cnt;
  } vec_t;

  vec_t v[$];

  task automatic add(input logic r, c, e, d, m, mq, f, input int cnt);
    v.push_back('{r, c, e, d, m, mq, f, cnt});
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Hand sequence step for b/c: drive, check Mealy outputs before the edge.
  task automatic step_bc(input int idx, input logic d, input logic mb, input logic mc);
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; en = 1'b1; din = d;
    #1;
    chk("b_match", idx, int'(ib.match), int'(mb));
    chk("c_match", idx, int'(ic.match), int'(mc));
    @(posedge clk);
    #1;
    chk("b_match_q", idx, int'(ib.match_q), int'(mb));
    chk("c_match_q", idx, int'(ic.match_q), int'(mc));
  endtask

  initial begin
    //   r  c  e  d   m  mq f  cnt
    add(1, 0, 0, 0,  0, 0, 0, 0);   // reset
    // 1,0,1,1,0,1,1 -> matches on bits 3 and 6
    add(0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 1, 0);
    add(0, 0, 1, 1,  1, 1, 1, 1);
    add(0, 0, 1, 0,  0, 0, 1, 1);
    add(0, 0, 1, 1,  0, 0, 1, 1);
    add(0, 0, 1, 1,  1, 1, 1, 2);
    // continue overlap stream: counter saturates at 3 with CNT_W=2
    add(0, 0, 1, 0,  0, 0, 1, 2);
    add(0, 0, 1, 1,  0, 0, 1, 2);
    add(0, 0, 1, 1,  1, 1, 1, 3);
    add(0, 0, 1, 0,  0, 0, 1, 3);
    add(0, 0, 1, 1,  0, 0, 1, 3);
    add(0, 0, 1, 1,  1, 1, 1, 3);
    // clr mid-stream overrides an otherwise matching bit
    add(0, 1, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 1, 0);
    add(0, 1, 1, 1,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 1, 0);
    add(0, 0, 1, 1,  1, 1, 1, 1);
    // en gaps: 1, gap x3, 0, 1, gap, 1
    add(0, 1, 0, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 1, 0);
    add(0, 0, 0, 1,  0, 0, 1, 0);
    add(0, 0, 1, 1,  1, 1, 1, 1);
    add(0, 0, 0, 1,  0, 0, 1, 1);
    // reset mid-pattern discards history and gates match
    add(0, 1, 0, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 1, 0);
    add(1, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 0, 1, 1,  0, 0, 1, 0);
    add(0, 0, 1, 1,  1, 1, 1, 1);

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      rst = v[i].r; clr = v[i].c; en = v[i].e; din = v[i].d;
      #1;
      chk("a_match", i, int'(ia.match), int'(v[i].m));
      @(posedge clk);
      #1;
      chk("a_match_q", i, int'(ia.match_q), int'(v[i].mq));
      chk("a_full", i, int'(ia.full), int'(v[i].f));
`ifdef SEQ_DETECTOR_COUNT_EN
      chk("a_count", i, int'(ia.count), v[i].cnt);
`endif
    end

    // 1010 pattern on 1,0,1,0,1,0: overlap vs restart
    @(negedge clk);
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    chk("b_full_rst", 0, int'(ib.full), 0);
    chk("c_full_rst", 0, int'(ic.full), 0);
    step_bc(0, 1'b1, 1'b0, 1'b0);
    step_bc(1, 1'b0, 1'b0, 1'b0);
    step_bc(2, 1'b1, 1'b0, 1'b0);
    step_bc(3, 1'b0, 1'b1, 1'b1);
    step_bc(4, 1'b1, 1'b0, 1'b0);
    step_bc(5, 1'b0, 1'b1, 1'b0);
    chk("b_full_end", 5, int'(ib.full), 1);
    chk("c_full_end", 5, int'(ic.full), 0);
`ifdef SEQ_DETECTOR_COUNT_EN
    chk("b_count", 5, int'(ib.count), 2);
    chk("c_count", 5, int'(ic.count), 1);
`endif

    @(negedge clk);
    en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter LEN, default 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011, LEN-bit target; PATTERN[LEN-1] is the first (oldest) bit received.
REQ-003 Parameter OVERLAP, default 1; 1 allows overlapping matches, 0 restarts the search after each match.
REQ-004 Parameter CNT_W, default 8, width of the match counter.
REQ-005 Port clk, input, 1, single clock; all state updates on posedge clk.
REQ-006 Port rst, input, 1; reset is synchronous and active-high.
REQ-007 Port en, input, 1, din is consumed only in cycles with en=1.
REQ-008 Port din, input, 1, serial data bit.
REQ-009 Port clr, input, 1, synchronous soft clear of search state and counter.
REQ-010 Port match, output, 1, Mealy match flag, combinational from current state and din/en/clr.
REQ-011 Port match_q, output, 1, match registered one cycle later.
REQ-012 Port full, output, 1, window holds LEN-1 valid bits (next consumed bit can complete a match).
REQ-013 Port count, output, CNT_W, number of matches since reset/clr (present only per REQ-027).

Function
REQ-014 State: LEN-1-bit history window win, fill counter fill (0..LEN-1), match_q register, count register.
REQ-015 match SHALL equal en & ~clr & (fill==LEN-1) & ({win,din}==PATTERN), with no latency.
REQ-016 When en=1 and clr=0, win SHALL shift left taking din as its LSB, and fill SHALL increment, saturating at LEN-1.
REQ-017 When match=1 and OVERLAP=0, fill SHALL load 0 instead of incrementing (win contents become don't-care).
REQ-018 When match=1 and OVERLAP=1, fill SHALL remain LEN-1 so the next bit can complete another match.
REQ-019 When en=0 and clr=0, win, fill and count SHALL hold; match_q SHALL load 0.
REQ-020 match_q SHALL load match every cycle (latency exactly 1 cycle).
REQ-021 count SHALL increment by 1 on each cycle with match=1 and saturate at 2^CNT_W-1 (no wrap).
REQ-022 clr=1 SHALL force fill, win, match_q and count to 0 on the next edge, overriding en and din in that cycle.
REQ-023 full SHALL equal (fill==LEN-1).

Reset
REQ-024 rst=1 at a clock edge SHALL set win=0, fill=0, match_q=0 and count=0; rst has priority over clr and en.
REQ-025 While rst=1, match SHALL be 0 (rst gates the Mealy term just as clr does).
REQ-026 Reset asserted mid-pattern SHALL discard partial history; the first match after reset needs LEN fresh en cycles.

Configuration
REQ-027 Macro SEQ_DETECTOR_COUNT_EN defined: count port and counter exist per REQ-021.
REQ-028 Macro SEQ_DETECTOR_COUNT_EN undefined: no count port and no counter register; all other behaviour is identical.

Verification
REQ-029 LEN=4, PATTERN=1011, OVERLAP=1, en=1, din=1,0,1,1,0,1,1 -> match high on bits 3 and 6, match_q high one cycle later, count=2.
REQ-030 PATTERN=1010, din=1,0,1,0,1,0: OVERLAP=1 -> matches on bits 3 and 5, count=2; OVERLAP=0 -> match on bit 3 only, count=1.
REQ-031 PATTERN=1011, din 1,0,1,1 with en=0 for 3 cycles inserted between bits 1 and 2 -> single match on the last valid bit; match=0 and match_q=0 during the gaps.
REQ-032 Stream 1,0,1 then clr=1 with en=1, din=1 -> match=0 that cycle; full=0 and count=0 afterwards; the next 1,0,1,1 matches.
REQ-033 CNT_W=2, 5 matches in the overlap stream 1,0,1,1,0,1,1,0,1,1,... -> count reads 1,2,3,3,3 (saturates).
REQ-034 rst=1 after bits 1,0,1 -> next bit 1 gives no match; full=0; count=0; 1,0,1,1 afterwards matches.
